// File: rtl/apb_pkg.sv
// Shared APB definitions: bridge FSM encoding, data width and a constant clog2.
package apb_pkg;

  localparam int APB_DW = 32;

  // Bridge FSM encoding, kept as plain constants for legacy tools.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  // Ceiling log2 for elaboration-time sizing; clog2(1) = 0.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/wb_apb_bridge_if.sv
// Wishbone-slave / APB-master signal bundle for wb_apb_bridge.
// The slave modport is the bridge; the master modport is everything around it
// (Wishbone initiator plus the APB peripherals).
// Handshake: a Wishbone request is valid while wb_cyc_i & wb_stb_i are high and
// is answered by exactly one single-cycle wb_ack_o or wb_err_o; on APB a transfer
// is one SETUP cycle (psel, !penable) then ACCESS (psel, penable) until the
// selected slave raises pready.
interface wb_apb_bridge_if #(
  parameter int NUM_SLAVES = 4
);
  import apb_pkg::*;

  logic                         wb_cyc_i;
  logic                         wb_stb_i;
  logic                         wb_we_i;
  logic [31:0]                  wb_adr_i;
  logic [APB_DW-1:0]            wb_dat_i;
  logic [APB_DW-1:0]            wb_dat_o;
  logic                         wb_ack_o;
  logic                         wb_err_o;
  logic [31:0]                  paddr;
  logic [APB_DW-1:0]            pwdata;
  logic                         pwrite;
  logic [NUM_SLAVES-1:0]        psel;
  logic                         penable;
  logic [APB_DW*NUM_SLAVES-1:0] prdata_i;
  logic [NUM_SLAVES-1:0]        pready_i;
  logic [NUM_SLAVES-1:0]        pslverr_i;
  logic [1:0]                   dbg_state;

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
    input  prdata_i, pready_i, pslverr_i,
    output wb_dat_o, wb_ack_o, wb_err_o,
    output paddr, pwdata, pwrite, psel, penable, dbg_state
  );

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
    output prdata_i, pready_i, pslverr_i,
    input  wb_dat_o, wb_ack_o, wb_err_o,
    input  paddr, pwdata, pwrite, psel, penable, dbg_state
  );

endinterface

// File: rtl/apb_addr_decode.sv
// Combinational APB window decoder: flags a hit when the address falls inside
// the NUM_SLAVES * 2^SLAVE_AW window at BASE_ADDR and the slave index exists,
// and produces the matching one-hot select.
module apb_addr_decode
  import apb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h4000_0000,
  parameter int          NUM_SLAVES = 4,
  parameter int          SLAVE_AW   = 12
) (
  input  logic [31:0]           addr,
  output logic                  hit,
  output logic [NUM_SLAVES-1:0] sel
);

  localparam int          SW       = clog2(NUM_SLAVES);
  localparam logic [31:0] WIN_MASK = ~((32'd1 << (SLAVE_AW + SW)) - 32'd1);

  logic [31:0] idx;
  logic        in_win;

  // Window compare, index extraction and one-hot expansion.
  always_comb begin
    sel    = '0;
    in_win = (addr & WIN_MASK) == (BASE_ADDR & WIN_MASK);
    idx    = (addr & ~WIN_MASK) >> SLAVE_AW;
    hit    = in_win && (idx < 32'(NUM_SLAVES));
    for (int i = 0; i < NUM_SLAVES; i++) begin
      sel[i] = hit && (idx == 32'(i));
    end
  end

endmodule

// File: rtl/wb_apb_bridge.sv
// Wishbone B4 classic slave to APB3 master bridge.
// Each Wishbone cycle becomes one APB SETUP/ACCESS transfer; misses in the
// decode window are answered with wb_err_o and never reach APB.
// Optional feature macro: WB2APB_TIMEOUT_EN -- when defined, an ACCESS phase
// lasting TIMEOUT_CYC cycles without pready is closed with wb_err_o.
module wb_apb_bridge
  import apb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h4000_0000,
  parameter int          NUM_SLAVES  = 4,
  parameter int          SLAVE_AW    = 12,
  parameter int          TIMEOUT_CYC = 16
) (
  input logic            pclk,
  input logic            preset,
  wb_apb_bridge_if.slave bus
);

  logic [1:0]            state_q;
  logic [NUM_SLAVES-1:0] psel_q;
  logic                  penable_q;
  logic                  pwrite_q;
  logic [31:0]           paddr_q;
  logic [APB_DW-1:0]     pwdata_q;
  logic                  ack_q;
  logic                  err_q;
  logic [APB_DW-1:0]     dat_q;
  logic                  aborted_q;

  logic                  dec_hit;
  logic [NUM_SLAVES-1:0] dec_sel;
  logic                  pready_sel;
  logic                  pslverr_sel;
  logic [APB_DW-1:0]     prdata_sel;
  logic                  wb_req;
  logic                  drop_resp;

  apb_addr_decode #(
    .BASE_ADDR  (BASE_ADDR),
    .NUM_SLAVES (NUM_SLAVES),
    .SLAVE_AW   (SLAVE_AW)
  ) u_dec (
    .addr (bus.wb_adr_i),
    .hit  (dec_hit),
    .sel  (dec_sel)
  );

  assign wb_req    = bus.wb_cyc_i & bus.wb_stb_i;
  // A cycle dropped at any point of the APB transfer must not be answered.
  assign drop_resp = aborted_q | ~bus.wb_cyc_i;

  // Response mux driven by the registered one-hot select, so only the selected
  // slave's pready/pslverr/prdata can ever be observed.
  always_comb begin
    pready_sel  = 1'b0;
    pslverr_sel = 1'b0;
    prdata_sel  = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (psel_q[i]) begin
        pready_sel  = pready_sel  | bus.pready_i[i];
        pslverr_sel = pslverr_sel | bus.pslverr_i[i];
        prdata_sel  = prdata_sel  | bus.prdata_i[APB_DW*i +: APB_DW];
      end
    end
  end

`ifdef WB2APB_TIMEOUT_EN
  localparam int TW = clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] tmo_cnt_q;
  logic          tmo_hit;

  assign tmo_hit = (tmo_cnt_q == TW'(TIMEOUT_CYC - 1));

  // ACCESS-phase stall counter, cleared on the SETUP->ACCESS edge.
  always_ff @(posedge pclk) begin
    if (preset) begin
      tmo_cnt_q <= '0;
    end else if (state_q == ST_SETUP) begin
      tmo_cnt_q <= '0;
    end else if (state_q == ST_ACCESS && !pready_sel && !tmo_hit) begin
      tmo_cnt_q <= tmo_cnt_q + TW'(1);
    end
  end
`else
  logic          tmo_hit;
  logic [31:0]   unused_tmo;

  // Without the timeout the bridge waits for pready indefinitely.
  assign tmo_hit    = 1'b0;
  assign unused_tmo = 32'(TIMEOUT_CYC);
`endif

  // Bridge FSM with registered APB and Wishbone outputs.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q   <= ST_IDLE;
      psel_q    <= '0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      dat_q     <= '0;
      aborted_q <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (wb_req) begin
            if (dec_hit) begin
              paddr_q   <= {{(32-SLAVE_AW){1'b0}}, bus.wb_adr_i[SLAVE_AW-1:0]};
              pwdata_q  <= bus.wb_dat_i;
              pwrite_q  <= bus.wb_we_i;
              psel_q    <= dec_sel;
              aborted_q <= 1'b0;
              state_q   <= ST_SETUP;
            end else begin
              err_q   <= 1'b1;
              state_q <= ST_RESP;
            end
          end
        end
        ST_SETUP: begin
          penable_q <= 1'b1;
          if (!bus.wb_cyc_i) aborted_q <= 1'b1;
          state_q <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (pready_sel) begin
            psel_q    <= '0;
            penable_q <= 1'b0;
            if (!pwrite_q) dat_q <= prdata_sel;
            if (drop_resp) begin
              state_q <= ST_IDLE;
            end else begin
              ack_q   <= ~pslverr_sel;
              err_q   <= pslverr_sel;
              state_q <= ST_RESP;
            end
          end else if (tmo_hit) begin
            psel_q    <= '0;
            penable_q <= 1'b0;
            if (drop_resp) begin
              state_q <= ST_IDLE;
            end else begin
              err_q   <= 1'b1;
              state_q <= ST_RESP;
            end
          end else if (!bus.wb_cyc_i) begin
            aborted_q <= 1'b1;
          end
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.psel      = psel_q;
  assign bus.penable   = penable_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.paddr     = paddr_q;
  assign bus.pwdata    = pwdata_q;
  assign bus.wb_ack_o  = ack_q;
  assign bus.wb_err_o  = err_q;
  assign bus.wb_dat_o  = dat_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_wb_apb_bridge.sv
// Directed testbench for wb_apb_bridge with a behavioural APB slave model
// (slave 0 behaves like apb_gpio with one wait cycle).
module tb_wb_apb_bridge;
  import apb_pkg::*;

  localparam int          NS   = 4;
  localparam logic [31:0] BASE = 32'h4000_0000;

  // ---------------- clock / reset ----------------
  logic pclk = 1'b0;
  logic preset;
  always #5 pclk = ~pclk;

  wb_apb_bridge_if #(.NUM_SLAVES(NS)) bus ();

  wb_apb_bridge #(
    .BASE_ADDR   (BASE),
    .NUM_SLAVES  (NS),
    .SLAVE_AW    (12),
    .TIMEOUT_CYC (16)
  ) dut (
    .pclk   (pclk),
    .preset (preset),
    .bus    (bus)
  );

  // ---------------- APB slave model ----------------
  int          wait_cyc [NS];
  logic [NS-1:0] force_rdy;
  logic [NS-1:0] err_en;
  logic [7:0]  acc_cnt;
  logic [3:0]  gpio_out;

  always @(posedge pclk) begin
    if (preset || !(bus.penable && (|bus.psel))) acc_cnt <= 8'd0;
    else acc_cnt <= acc_cnt + 8'd1;
    if (preset) gpio_out <= 4'h0;
    else if (bus.psel[0] && bus.penable && bus.pready_i[0] && bus.pwrite)
      gpio_out <= bus.pwdata[3:0];
  end

  always_comb begin
    bus.pready_i  = '0;
    bus.pslverr_i = '0;
    bus.prdata_i  = '0;
    for (int s = 0; s < NS; s++) begin
      bus.pready_i[s]  = force_rdy[s] |
                         (bus.psel[s] & bus.penable & (acc_cnt == 8'(wait_cyc[s])));
      bus.pslverr_i[s] = err_en[s] & bus.psel[s] & bus.penable;
      bus.prdata_i[32*s +: 32] = (s == 1) ? 32'hDEAD_BEEF : (32'h1111_0000 + 32'(s));
    end
  end

  // ---------------- scoreboard ----------------
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic wb_req(input logic we, input logic [31:0] adr, input logic [31:0] dat);
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    bus.wb_we_i  = we;
    bus.wb_adr_i = adr;
    bus.wb_dat_i = dat;
  endtask

  task automatic wb_idle();
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i  = 1'b0;
  endtask

  // Advance until ack/err, counting cycles from the request; bounded.
  task automatic wait_done(input string tag, input int start, output int cyc_n);
    cyc_n = start;
    while (!(bus.wb_ack_o || bus.wb_err_o) && cyc_n < 64) begin
      tick();
      cyc_n++;
    end
    check_val({tag, "_done"}, 32'(bus.wb_ack_o | bus.wb_err_o), 32'd1);
  endtask

  int n_setup, n_ack, a1, a2, cyc_n;

  initial begin
    preset    = 1'b1;
    force_rdy = '0;
    err_en    = '0;
    wait_cyc  = '{1, 3, 0, 200};
    bus.wb_adr_i = '0;
    bus.wb_dat_i = '0;
    wb_idle();
    tick(); tick(); tick();

    // Reset state
    check_val("rst_psel",  32'(bus.psel), 32'h0);
    check_val("rst_pen",   32'(bus.penable), 32'h0);
    check_val("rst_ack",   32'(bus.wb_ack_o | bus.wb_err_o), 32'h0);
    check_val("rst_dat",   bus.wb_dat_o, 32'h0);
    check_val("rst_paddr", bus.paddr, 32'h0);
    check_val("rst_state", 32'(bus.dbg_state), 32'(ST_IDLE));
    preset = 1'b0;
    tick();

    // Write 0xA5 to gpio (slave 0): ack at cycle 4
    wb_req(1'b1, BASE, 32'hA5);
    tick();
    check_val("wr_c1_psel",  32'(bus.psel), 32'h1);
    check_val("wr_c1_pen",   32'(bus.penable), 32'h0);
    check_val("wr_c1_state", 32'(bus.dbg_state), 32'(ST_SETUP));
    tick();
    check_val("wr_c2_pen",    32'(bus.penable), 32'h1);
    check_val("wr_c2_pwdata", bus.pwdata, 32'hA5);
    check_val("wr_c2_pwrite", 32'(bus.pwrite), 32'h1);
    tick();
    check_val("wr_c3_ack", 32'(bus.wb_ack_o), 32'h0);
    tick();
    check_val("wr_c4_ack", 32'(bus.wb_ack_o), 32'h1);
    check_val("wr_c4_err", 32'(bus.wb_err_o), 32'h0);
    wb_idle();
    tick();
    check_val("wr_c5_ack",   32'(bus.wb_ack_o), 32'h0);
    check_val("wr_c5_state", 32'(bus.dbg_state), 32'(ST_IDLE));
    check_val("wr_gpio",     32'(gpio_out), 32'h5);
    check_val("wr_dat_keep", bus.wb_dat_o, 32'h0);

    // Read slave 1 with 3 wait states, other slaves shouting pready
    force_rdy = 4'b1101;
    exp_q.push_back(32'hDEAD_BEEF);
    wb_req(1'b0, BASE + 32'h1004, 32'h0);
    tick();
    check_val("rd_psel",  32'(bus.psel), 32'h2);
    check_val("rd_paddr", bus.paddr, 32'h004);
    wait_done("rd", 1, cyc_n);
    check_val("rd_cycle", 32'(cyc_n), 32'd6);
    check_val("rd_ack",   32'(bus.wb_ack_o), 32'h1);
    check_val("rd_data",  bus.wb_dat_o, exp_q.pop_front());
    wb_idle();
    force_rdy = '0;
    tick();

    // Out-of-window access: error next cycle, no APB activity
    wb_req(1'b0, BASE + 32'h4000, 32'h0);
    tick();
    check_val("miss_err",   32'(bus.wb_err_o), 32'h1);
    check_val("miss_ack",   32'(bus.wb_ack_o), 32'h0);
    check_val("miss_psel",  32'(bus.psel), 32'h0);
    check_val("miss_state", 32'(bus.dbg_state), 32'(ST_RESP));
    wb_idle();
    tick();
    check_val("miss_idle",  32'(bus.dbg_state), 32'(ST_IDLE));

    // Slave 2 write answered with pslverr
    err_en = 4'b0100;
    wb_req(1'b1, BASE + 32'h2010, 32'h1234);
    wait_done("slverr", 0, cyc_n);
    check_val("slverr_cycle", 32'(cyc_n), 32'd3);
    check_val("slverr_err",   32'(bus.wb_err_o), 32'h1);
    check_val("slverr_ack",   32'(bus.wb_ack_o), 32'h0);
    check_val("slverr_dat",   bus.wb_dat_o, 32'hDEAD_BEEF);
    wb_idle();
    err_en = '0;
    tick();
    check_val("slverr_idle",  32'(bus.dbg_state), 32'(ST_IDLE));

    // Back-to-back writes with stb held, stale gpio pready
    force_rdy = 4'b0001;
    n_setup = 0; n_ack = 0; a1 = 0; a2 = 0;
    wb_req(1'b1, BASE, 32'h3);
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (bus.psel != '0 && !bus.penable) n_setup++;
      if (bus.wb_ack_o) begin
        n_ack++;
        if (n_ack == 1) a1 = c;
        else a2 = c;
        if (n_ack == 2) wb_idle();
      end
    end
    force_rdy = '0;
    check_val("b2b_setups", 32'(n_setup), 32'd2);
    check_val("b2b_acks",   32'(n_ack), 32'd2);
    check_val("b2b_ack1",   32'(a1), 32'd3);
    check_val("b2b_ack2",   32'(a2), 32'd7);

    // Abort in SETUP: APB completes, no ack
    wb_req(1'b1, BASE, 32'h7);
    tick();
    wb_idle();
    tick(); tick(); tick();
    check_val("abort_ack",   32'(bus.wb_ack_o | bus.wb_err_o), 32'h0);
    check_val("abort_state", 32'(bus.dbg_state), 32'(ST_IDLE));
    check_val("abort_gpio",  32'(gpio_out), 32'h7);

    // Reset while waiting in ACCESS on a slow slave
    wb_req(1'b0, BASE + 32'h3000, 32'h0);
    tick(); tick(); tick();
    check_val("rstmid_acc", 32'(bus.dbg_state), 32'(ST_ACCESS));
    preset = 1'b1;
    tick();
    check_val("rstmid_psel", 32'(bus.psel), 32'h0);
    check_val("rstmid_pen",  32'(bus.penable), 32'h0);
    check_val("rstmid_ack",  32'(bus.wb_ack_o | bus.wb_err_o), 32'h0);
    wb_idle();
    preset = 1'b0;
    tick();
    check_val("rstmid_idle", 32'(bus.dbg_state), 32'(ST_IDLE));

`ifdef WB2APB_TIMEOUT_EN
    // pready never arrives: forced error at cycle 18
    wb_req(1'b0, BASE + 32'h3008, 32'h0);
    wait_done("tmo", 0, cyc_n);
    check_val("tmo_cycle", 32'(cyc_n), 32'd18);
    check_val("tmo_err",   32'(bus.wb_err_o), 32'h1);
    check_val("tmo_ack",   32'(bus.wb_ack_o), 32'h0);
    check_val("tmo_psel",  32'(bus.psel), 32'h0);
    check_val("tmo_dat",   bus.wb_dat_o, 32'h0);
    wb_idle();
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
